mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port, synchronous-read main memory (11-bit address, 16-bit data, rd/wr strobes, registered read data).
- Port 0 is the CPU instruction-fetch path; port 1 is the CPU load/store path.
- Serialises accesses, drives the memory strobes one at a time, and returns read data or write completion to the winning requester.

Parameters:
- AW, 11, address width (2048 words).
- DW, 16, data width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request; held, with its qualifiers, until the matching gnt.
- we0 / we1  in  1  1 = write, 0 = read; qualifies req.
- addr0 / addr1  in  AW  word address; qualifies req.
- wdata0 / wdata1  in  DW  write data; qualifies req with we=1.
- gnt0 / gnt1  out  1  combinational; request accepted at this clock edge.
- done0 / done1  out  1  registered 1-cycle pulse; access complete.
- rdata0 / rdata1  out  DW  registered read data; valid while done=1 for a read, holds last value otherwise.
- mem_address  out  AW  registered memory address.
- mem_data_in  out  DW  registered memory write data.
- mem_rd / mem_wr  out  1  registered memory strobes; never both 1.
- mem_data_out  in  DW  memory read data, valid the cycle after the mem_rd edge.

Behaviour:
- States: IDLE, ISSUE, CAPTURE.
- IDLE:
  - If any req, the winner's gnt=1 (combinational; at most one gnt).
  - At the edge: latch addr, we, wdata and winner id; go to ISSUE.
  - No req: stay in IDLE.
- ISSUE:
  - mem_rd=~we_l, mem_wr=we_l, mem_address=addr_l, mem_data_in=wdata_l.
  - Read: go to CAPTURE.
  - Write: go to IDLE and pulse done of the winner in the following cycle.
- CAPTURE:
  - Strobes 0; mem_data_out valid.
  - At the edge: rdata_winner <= mem_data_out, done_winner <= 1, go to IDLE.
- Latency, with the gnt edge = E0:
  - Read: mem_rd high in cycle E0..E1; done high in cycle E2..E3 (3 cycles).
  - Write: mem_wr high in cycle E0..E1; done high in cycle E1..E2 (2 cycles).
- Throughput:
  - A new gnt is allowed in the same cycle a done pulse is high, since the FSM is back in IDLE.
  - Back-to-back reads: one every 3 cycles. Back-to-back writes: one every 2 cycles.
- Arbitration:
  - Round-robin. Pointer last_win is updated at each grant.
  - Both requesting: the port other than last_win wins.
  - last_win resets to 1, so port 0 wins the first tie.
  - A lone requester always wins.
- gnt is never asserted outside IDLE; reqs arriving during ISSUE or CAPTURE wait.
- Address and data pass through unchanged: no arithmetic, no wrap logic. Address 2047 is a normal address.
- Reset (async, any state):
  - state=IDLE, last_win=1.
  - mem_rd=mem_wr=0, mem_address=0, mem_data_in=0.
  - done0=done1=0, rdata0=rdata1=0.
  - An in-flight access is dropped with no done. If reset is asserted during ISSUE, the strobe falls immediately.
- Requester protocol violations (req dropped before gnt, qualifiers changing) are not checked. The request is sampled only on the gnt edge.

Optional Feature:
- Macro MEMARB_FIXED_PRIO_EN.
- Defined:
  - Round-robin logic removed; port 1 (load/store) always beats port 0 on a tie.
  - Port 0 wins only when req1=0.
  - last_win is not implemented.
- Undefined: round-robin as above.

Test Plan:
- Single read: mem[10]=16'h0009, req0 with we0=0, addr0=10 → gnt0 one cycle; mem_rd=1 with mem_address=10 for one cycle; done0 pulse 3 cycles after the gnt edge with rdata0=16'h0009; gnt1/done1 stay 0.
- Single write then readback: req1 with we1=1, addr1=12, wdata1=16'h0005 → mem_wr one cycle; done1 2 cycles after gnt. Then read addr 12 → rdata1=16'h0005.
- Tie, round-robin:
  - req0 and req1 held high (reads of 0 and 1) → grant order 0,1,0,1.
  - mem_rd and mem_wr never both 1.
  - With MEMARB_FIXED_PRIO_EN: port 1 granted every time while req1 is held.
- Request during busy: req1 raised while port 0's read is in ISSUE → gnt1 withheld until the IDLE cycle in which done0 pulses, then granted.
- Reset mid-operation:
  - Drop rst_n during ISSUE of a write to addr 11 → mem_wr=0 immediately, all outputs 0, no done.
  - After release, a new req0 read of addr 11 returns the pre-existing value 16'hFFFC.
- Address boundary: write 16'hABCD to addr 2047, then read it back → rdata=16'hABCD; addr 0 unaffected.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of a single-port,
// synchronous-read memory. Port 0 is instruction fetch, port 1 is load/store.
// Every access is serialised through IDLE -> ISSUE [-> CAPTURE] -> IDLE.
// Optional build macro MEMARB_FIXED_PRIO_EN: port 1 always wins a tie, and
// no round-robin pointer is kept.
module mem_arbiter #(
  parameter int AW = 11,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t state;
  logic   we_l;   // latched direction of the access in flight
  logic   id_l;   // latched winner: 0 = port 0, 1 = port 1
`ifndef MEMARB_FIXED_PRIO_EN
  logic   last_win;
`endif

  // Selected requester's qualifiers, chosen by the grant.
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Combinational grant: only in IDLE, at most one port at a time.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
`ifdef MEMARB_FIXED_PRIO_EN
      gnt1 = req1;
      gnt0 = req0 & ~req1;
`else
      if (req0 && req1) begin
        gnt0 = last_win;
        gnt1 = ~last_win;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
`endif
    end
  end

  // Qualifier mux for the winning port.
  always_comb begin
    sel_we    = gnt1 ? we1    : we0;
    sel_addr  = gnt1 ? addr1  : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;
  end

  // Sequencer FSM with registered memory strobes and completion pulses.
  // Address and write data are loaded straight into the memory-side
  // registers at the grant edge, so they already sit on the bus during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_l        <= 1'b0;
      id_l        <= 1'b0;
`ifndef MEMARB_FIXED_PRIO_EN
      last_win    <= 1'b1;
`endif
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      done0  <= 1'b0;
      done1  <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            id_l        <= gnt1;
            we_l        <= sel_we;
            mem_address <= sel_addr;
            mem_data_in <= sel_wdata;
            mem_rd      <= ~sel_we;
            mem_wr      <= sel_we;
`ifndef MEMARB_FIXED_PRIO_EN
            last_win    <= gnt1;
`endif
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_l) begin
            if (id_l) done1 <= 1'b1;
            else      done0 <= 1'b1;
            state <= IDLE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (id_l) begin
            rdata1 <= mem_data_out;
            done1  <= 1'b1;
          end else begin
            rdata0 <= mem_data_out;
            done0  <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. A behavioural memory
// sits on the memory port; a reference model predicts each grant from the
// arbitration rules, records the expected completion cycle and data in a
// per-port queue, and a monitor pops and compares on every done pulse.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [10:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] rdata0, rdata1;
  logic [10:0] mem_address;
  logic [15:0] mem_data_in;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_data_out;

  mem_arbiter #(.AW(11), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with registered read data.
  logic [15:0] mem [2048];
  logic [15:0] mem_q = '0;
  always @(posedge clk) begin
    if (mem_wr) mem[mem_address] <= mem_data_in;
    if (mem_rd) mem_q <= mem[mem_address];
  end
  assign mem_data_out = mem_q;

  // Reference model state.
  typedef struct {
    bit          we;
    logic [15:0] exp;
    int          due;
    logic [10:0] addr;
    logic [15:0] old;
  } txn_t;

  logic [15:0] ref_mem [2048];
  txn_t        q [2][$];
  int          cyc = 0;
  int          busy_until = 0;
  int          last_w = 1;
  int          compared = 0;
  int          mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor and grant predictor, sampled mid-cycle.
  logic [1:0]  d_v, exp_g;
  logic [15:0] rd_v [2];
  txn_t        t;
  int          w;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("strobe_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
      d_v = {done1, done0};
      rd_v[0] = rdata0;
      rd_v[1] = rdata1;
      for (int p = 0; p < 2; p++) begin
        if (d_v[p]) begin
          if (q[p].size() == 0) begin
            chk($sformatf("spurious_done%0d", p), 32'd1, 32'd0);
          end else begin
            t = q[p].pop_front();
            chk($sformatf("done_cycle%0d", p), cyc, t.due);
            if (!t.we) chk($sformatf("rdata%0d", p), {16'd0, rd_v[p]}, {16'd0, t.exp});
          end
        end else if (q[p].size() > 0 && q[p][0].due < cyc) begin
          chk($sformatf("missing_done%0d", p), cyc, q[p][0].due);
          void'(q[p].pop_front());
        end
      end
      exp_g = 2'b00;
      if (cyc >= busy_until) begin
        if (req0 && req1) begin
`ifdef MEMARB_FIXED_PRIO_EN
          exp_g = 2'b10;
`else
          exp_g = (last_w == 1) ? 2'b01 : 2'b10;
`endif
        end else begin
          exp_g = {req1, req0};
        end
      end
      chk("gnt", {30'd0, gnt1, gnt0}, {30'd0, exp_g});
      if (exp_g != 2'b00) begin
        w      = exp_g[1] ? 1 : 0;
        t.we   = (w == 1) ? we1 : we0;
        t.addr = (w == 1) ? addr1 : addr0;
        t.due  = cyc + (t.we ? 2 : 3);
        t.old  = ref_mem[t.addr];
        if (t.we) begin
          t.exp = '0;
          ref_mem[t.addr] = (w == 1) ? wdata1 : wdata0;
        end else begin
          t.exp = ref_mem[t.addr];
        end
        q[w].push_back(t);
        busy_until = t.due;
        last_w = w;
      end
    end
  end

  // Raise a request on port p and hold it until it is granted.
  task automatic issue(input int p, input bit we, input logic [10:0] a, input logic [15:0] d);
    int n = 0;
    bit g;
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    do begin
      @(negedge clk);
      n++;
      g = (p == 0) ? gnt0 : gnt1;
    end while (!g && n < 300);
    if (!g) chk($sformatf("gnt_timeout%0d", p), n, 32'd0);
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic gap(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [10:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 11'd0;
      1: return 11'd1;
      2: return 11'd11;
      3: return 11'd12;
      4: return 11'd2047;
      default: return 11'($urandom_range(0, 2047));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'(i * 3) ^ 16'h5A5A;
    mem[10] = 16'h0009;
    mem[11] = 16'hFFFC;
    for (int i = 0; i < 2048; i++) ref_mem[i] = mem[i];

    // Reset state.
    #22;
    chk("rst_strobes", {28'd0, mem_rd, mem_wr, done0, done1}, 32'd0);
    chk("rst_mem_address", {21'd0, mem_address}, 32'd0);
    chk("rst_mem_data_in", {16'd0, mem_data_in}, 32'd0);
    chk("rst_rdata", {rdata1, rdata0}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    gap(1);

    // Single read, write then readback.
    issue(0, 1'b0, 11'd10, 16'h0);
    issue(1, 1'b1, 11'd12, 16'h0005);
    issue(1, 1'b0, 11'd12, 16'h0);

    // Tie with both requests held: alternating grants (or port 1 only).
    fork
      begin for (int i = 0; i < 4; i++) issue(0, 1'b0, 11'd0, 16'h0); end
      begin for (int i = 0; i < 4; i++) issue(1, 1'b0, 11'd1, 16'h0); end
    join

    // Request arriving while the other port's read is in ISSUE.
    fork
      issue(0, 1'b0, 11'd10, 16'h0);
      begin gap(1); issue(1, 1'b0, 11'd11, 16'h0); end
    join

    // Top address is an ordinary location.
    issue(1, 1'b1, 11'd2047, 16'hABCD);
    issue(0, 1'b0, 11'd2047, 16'h0);
    issue(0, 1'b0, 11'd0, 16'h0);

    // Reset during ISSUE of a write: strobe drops at once, access dropped.
    gap(2);
    issue(0, 1'b1, 11'd11, 16'h1234);
    chk("wr_in_issue", {31'd0, mem_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_strobes", {28'd0, mem_rd, mem_wr, done0, done1}, 32'd0);
    chk("midrst_mem_address", {21'd0, mem_address}, 32'd0);
    chk("midrst_mem_data_in", {16'd0, mem_data_in}, 32'd0);
    chk("midrst_rdata", {rdata1, rdata0}, 32'd0);
    for (int p = 0; p < 2; p++)
      while (q[p].size() > 0) begin
        t = q[p].pop_back();
        if (t.we) ref_mem[t.addr] = t.old;
      end
    busy_until = 0;
    last_w = 1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    gap(1);
    issue(0, 1'b0, 11'd11, 16'h0);

    // Randomised traffic from both ports.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          gap($urandom_range(0, 3));
          issue(0, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          gap($urandom_range(0, 3));
          issue(1, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
        end
      end
    join

    repeat (8) @(negedge clk);
    chk("drain0", q[0].size(), 32'd0);
    chk("drain1", q[1].size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
